mult_8_seq: RTL and testbench

- Sequential 8x8 unsigned shift-and-add multiplier; the ALU's multiply path.
- Sits downstream of csa_8 and consumes it: each iteration feeds one partial-product addition through a single csa_8 instance, trading latency for area.
- start/ready/done handshake toward the ALU control; 16-bit registered product.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/csa_8.sv | 37 +++
 rtl/mult_8_seq.sv | 141 ++++++++++++++
 tb/tb_mult_8_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the ALU datapath blocks.
//   ALU_W      : datapath operand width (8)
//   MUL_CNT_W  : multiplier iteration counter width (log2 ALU_W)
//   MUL_P_W    : multiplier product / partial-product register width (16)
//   mul_state_t: sequential multiplier control states
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W     = 8;
    localparam int MUL_CNT_W = 3;
    localparam int MUL_P_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/csa_8.sv
// ----------------------------------------------------------------------------
// csa_8
// 8-bit carry-select adder: {cout_o, sum_o} = a_i + b_i + cin_i.
// The upper nibble is precomputed for both carry-in values and selected by
// the carry out of the lower nibble.
// Ports:
//   a_i, b_i   in  [7:0]  addends
//   cin_i      in         carry in
//   sum_o      out [7:0]  sum
//   cout_o     out        carry out of bit 7
//   prevout_o  out        carry into bit 7 (for signed overflow = cout^prevout)
// ----------------------------------------------------------------------------
module csa_8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o,
    output logic       prevout_o
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    assign lo  = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0000, cin_i};
    assign hi0 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
    assign hi1 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + 5'd1;

    assign sum_o[3:0] = lo[3:0];
    assign sum_o[7:4] = lo[4] ? hi1[3:0] : hi0[3:0];
    assign cout_o     = lo[4] ? hi1[4]   : hi0[4];

    // Carry into the MSB recovered from the MSB sum bit: s7 = a7 ^ b7 ^ c7.
    assign prevout_o  = a_i[7] ^ b_i[7] ^ sum_o[7];

endmodule

// File: rtl/mult_8_seq.sv
// ----------------------------------------------------------------------------
// mult_8_seq
// Sequential 8x8 unsigned shift-and-add multiplier (ALU multiply path).
// One csa_8 instance performs one partial-product addition per cycle;
// an operation takes 8 CALC cycles plus one DONE cycle (one op per 10 cycles).
// Ports:
//   clk      in          rising-edge clock
//   rst_n    in          asynchronous active-low reset
//   start    in          request, accepted only on an edge where ready=1
//   a, b     in  [7:0]   multiplicand / multiplier, sampled on the accepting edge
//   ready    out         high in IDLE only
//   busy     out         high in CALC and DONE
//   done     out         one-cycle pulse, product valid
//   product  out [15:0]  registered a*b, held until the next accepted start
//   ovf      out         (MULT_OVF_EN only) |product[15:8], registered with product
// Build option: define MULT_OVF_EN to add the ovf port and its register.
// Handshake: start is sampled on a rising edge; it is taken only when ready
// is high on that edge, otherwise it is dropped (never queued).
// ----------------------------------------------------------------------------
module mult_8_seq
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
`ifdef MULT_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     m_q, m_d;
    logic [2*W-1:0]   p_q, p_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic [2*W-1:0]   p_next;
    logic [W-1:0]     add_sum;
    logic             add_cout;

    // Upper half of P plus the multiplicand; the carry becomes the new P[15].
    csa_8 u_csa (
        .a_i       (p_q[2*W-1:W]),
        .b_i       (m_q),
        .cin_i     (1'b0),
        .sum_o     (add_sum),
        .cout_o    (add_cout),
        .prevout_o ()
    );

    // Add M when the current multiplier LSB is set, then shift right by one.
    assign p_next = p_q[0] ? {add_cout, add_sum, p_q[W-1:1]}
                           : {1'b0, p_q[2*W-1:W], p_q[W-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        p_d     = p_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    m_d     = a;
                    p_d     = {{W{1'b0}}, b};
                    cnt_d   = '0;
                end
            end
            CALC: begin
                p_d   = p_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    prod_d  = p_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            p_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            p_q     <= p_d;
            prod_q  <= prod_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = prod_q;

`ifdef MULT_OVF_EN
    logic ovf_q, ovf_d;

    // Tracks product: updated only on the edge that writes the final result.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == CALC && cnt_q == LAST) begin
            ovf_d = |p_next[2*W-1:W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mult_8_seq.sv
// ----------------------------------------------------------------------------
// tb_mult_8_seq
// Self-checking bench for mult_8_seq. A reference model decides from the
// start/a/b stimulus alone when a request is taken, what the product is and
// on which cycle done must pulse; a monitor compares the DUT every cycle.
// Define MULT_OVF_EN for both DUT and bench to cover the ovf output.
// ----------------------------------------------------------------------------
module tb_mult_8_seq;

    // ------------------------------------------------------------ clock/reset
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;
`ifdef MULT_OVF_EN
    logic        ovf;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    mult_8_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
`ifdef MULT_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    // ------------------------------------------------------------ scoreboard
    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    int          next_ok    = 0;   // first cycle the model allows a new accept
    int          acc_cnt    = 0;
    logic [15:0] model_prod = '0;
    int          n_checks   = 0;
    int          n_fail     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        exp_cyc_q.delete();
        next_ok    = 0;
        model_prod = '0;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_rdy;
            exp_rdy = (cyc >= next_ok);
            chk("ready", {31'd0, ready}, {31'd0, exp_rdy});
            chk("busy",  {31'd0, busy},  {31'd0, !exp_rdy});
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [15:0] e;
                    int          ec;
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    model_prod = e;
                    chk("product", {16'd0, product}, {16'd0, e});
                    chk("done_cycle", cyc, ec);
                end
            end else begin
                if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
                    chk("missing_done", 32'd0, 32'd1);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
                chk("product_hold", {16'd0, product}, {16'd0, model_prod});
            end
`ifdef MULT_OVF_EN
            chk("ovf", {31'd0, ovf}, {31'd0, |model_prod[15:8]});
`endif
            // Reference: a request is taken when the block is idle; the
            // result appears 9 cycles later and the block is free after 10.
            if (start && exp_rdy) begin
                exp_q.push_back(16'(int'(a) * int'(b)));
                exp_cyc_q.push_back(cyc + 9);
                next_ok = cyc + 10;
                acc_cnt++;
            end
        end
    end

    // ------------------------------------------------------------ driver tasks
    task automatic issue(input logic [7:0] av, input logic [7:0] bv);
        int  c0;
        bit  got;
        c0  = acc_cnt;
        got = 1'b0;
        start = 1'b1;
        a     = av;
        b     = bv;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            if (acc_cnt != c0) got = 1'b1;
        end
        #2;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && cyc >= next_ok) ok = 1'b1;
        end
        #2;
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3 rst_n = 1'b0;
        #5;
        chk("rst_product", {16'd0, product}, 32'd0);
        chk("rst_ready",   {31'd0, ready},   32'd1);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_done",    {31'd0, done},    32'd0);
`ifdef MULT_OVF_EN
        chk("rst_ovf",     {31'd0, ovf},     32'd0);
`endif
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // Directed values including boundaries.
        issue(8'd13, 8'd11);   wait_idle();
        issue(8'hFF, 8'hFF);   wait_idle();
        issue(8'h00, 8'hA5);   wait_idle();
        issue(8'h01, 8'h80);   wait_idle();

        // Second request during the 4th CALC cycle must be dropped.
        issue(8'd3, 8'd5);
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #2;
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the 5th CALC cycle aborts the operation.
        issue(8'h80, 8'h80);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_product", {16'd0, product}, 32'd0);
        chk("abort_busy",    {31'd0, busy},    32'd0);
        chk("abort_ready",   {31'd0, ready},   32'd1);
        chk("abort_done",    {31'd0, done},    32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        issue(8'd2, 8'd3);     wait_idle();

        // start held high: back-to-back accepts every 10 cycles.
        start = 1'b1; a = 8'd7; b = 8'd9;
        repeat (30) @(posedge clk);
        #2 start = 1'b0;
        wait_idle();

        // Random traffic, including starts while busy and junk operands.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       a = 8'hFF;
                1:       a = 8'h00;
                default: a = 8'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = 8'hFF;
                1:       b = 8'h00;
                default: b = 8'($urandom);
            endcase
            @(posedge clk); #2;
        end
        start = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
